// File: rtl/booth4_pkg.sv
// Shared widths, row-placement helpers and the sign-extension constant row for the
// radix-4 Booth partial-product reduction pipeline.
package booth4_pkg;

  localparam int PP_W     = 17;
  localparam int PP_NUM   = 8;
  localparam int P_W      = 32;
  localparam int ROW_STEP = 2;
  localparam int S1_ROWS  = 5;

  typedef logic [P_W-1:0] word_t;

  typedef struct packed {
    word_t sum;
    word_t carry;
  } sc_t;

  function automatic int row_off(input int i);
    return i * ROW_STEP;
  endfunction

  // Each row enters the tree with its MSB inverted, which biases it by +2^(PP_W-1).
  // This constant cancels all of those biases at once: -sum_i 2^(PP_W-1+2i).
  function automatic word_t sext_const(input int pp_w, input int pp_num);
    word_t acc;
    acc = '0;
    for (int i = 0; i < pp_num; i++) begin
      acc = acc + (word_t'(1) << (pp_w - 1 + row_off(i)));
    end
    return ~acc + word_t'(1);
  endfunction

  localparam word_t SEXT_CONST = sext_const(PP_W, PP_NUM);

endpackage

// File: rtl/csa_3_2.sv
// One row of 3:2 carry-save compressors: sum = a^b^c, carry = majority(a,b,c) at the next weight.
// Purely combinational; a carry out of the top bit is dropped, so results are modulo 2^W.
module csa_3_2 #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  logic [W-1:0] maj;

  always_comb begin
    maj   = (a & b) | (a & c) | (b & c);
    sum   = a ^ b ^ c;
    carry = maj << 1;
  end

endmodule

// File: rtl/booth4_wallace_pipe.sv
// Booth radix-4 Wallace reducer: 8 pp rows + neg row + constant row -> sum/carry in 2 stages.
// Define BOOTH_FINAL_CPA_EN to add a third stage producing out_prod; valid/ready with full throughput.
module booth4_wallace_pipe #(
  parameter int PP_W   = booth4_pkg::PP_W,
  parameter int PP_NUM = booth4_pkg::PP_NUM,
  parameter int P_W    = booth4_pkg::P_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PP_NUM*PP_W-1:0] pp_bus,
  input  logic [PP_NUM-1:0]      neg_bus,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [P_W-1:0]         out_sum,
  output logic [P_W-1:0]         out_carry
`ifdef BOOTH_FINAL_CPA_EN
  ,
  output logic [P_W-1:0]         out_prod
`endif
);
  import booth4_pkg::*;

  localparam int NROW      = PP_NUM + 2;
  localparam int NEG_ROW   = PP_NUM;
  localparam int CONST_ROW = PP_NUM + 1;
  localparam logic [P_W-1:0] CONST_VAL = sext_const(PP_W, PP_NUM);

  // ---------------- row formation ----------------
  logic [P_W-1:0] row [NROW];

  always_comb begin
    for (int i = 0; i < NROW; i++) begin
      row[i] = '0;
    end
    for (int i = 0; i < PP_NUM; i++) begin
      row[i][PP_W-1:0] = {~pp_bus[i*PP_W + PP_W - 1], pp_bus[i*PP_W +: PP_W-1]};
      row[i] = row[i] << row_off(i);
      row[NEG_ROW][row_off(i)] = neg_bus[i];
    end
    row[CONST_ROW] = CONST_VAL;
  end

  // ---------------- S1: CSA layers 1-2 (10 -> 5 rows) ----------------
  logic [P_W-1:0] l1 [6];
  logic [P_W-1:0] l2 [4];

  for (genvar g = 0; g < 3; g++) begin : g_l1
    csa_3_2 #(.W(P_W)) u_csa (
      .a    (row[3*g]),
      .b    (row[3*g+1]),
      .c    (row[3*g+2]),
      .sum  (l1[2*g]),
      .carry(l1[2*g+1])
    );
  end

  for (genvar g = 0; g < 2; g++) begin : g_l2
    csa_3_2 #(.W(P_W)) u_csa (
      .a    (l1[3*g]),
      .b    (l1[3*g+1]),
      .c    (l1[3*g+2]),
      .sum  (l2[2*g]),
      .carry(l2[2*g+1])
    );
  end

  logic                            v1_q, v1_d;
  logic [S1_ROWS-1:0][P_W-1:0]     s1_q, s1_d;

  // ---------------- S2: CSA layers 3-5 (5 -> 2 rows) ----------------
  logic [P_W-1:0] l3 [2];
  logic [P_W-1:0] l4 [2];
  logic [P_W-1:0] l5 [2];

  csa_3_2 #(.W(P_W)) u_csa_l3 (
    .a(s1_q[0]), .b(s1_q[1]), .c(s1_q[2]), .sum(l3[0]), .carry(l3[1])
  );
  csa_3_2 #(.W(P_W)) u_csa_l4 (
    .a(l3[0]), .b(l3[1]), .c(s1_q[3]), .sum(l4[0]), .carry(l4[1])
  );
  csa_3_2 #(.W(P_W)) u_csa_l5 (
    .a(l4[0]), .b(l4[1]), .c(s1_q[4]), .sum(l5[0]), .carry(l5[1])
  );

  logic v2_q, v2_d;
  sc_t  s2_q, s2_d;
  logic ld1, ld2;

`ifdef BOOTH_FINAL_CPA_EN
  logic           v3_q, v3_d;
  sc_t            s3_q, s3_d;
  logic [P_W-1:0] prod_q, prod_d;
  logic           ld3;
`endif

  // ---------------- handshake and next-state ----------------
  always_comb begin
`ifdef BOOTH_FINAL_CPA_EN
    ld3 = v2_q && (!v3_q || out_ready);
    ld2 = v1_q && (!v2_q || ld3);
`else
    ld2 = v1_q && (!v2_q || out_ready);
`endif
    in_ready = !v1_q || ld2;
    ld1      = in_valid && in_ready;

    v1_d = ld1 || (v1_q && !ld2);
    s1_d = s1_q;
    if (ld1) begin
      for (int j = 0; j < 4; j++) begin
        s1_d[j] = l2[j];
      end
      s1_d[4] = row[CONST_ROW];
    end

`ifdef BOOTH_FINAL_CPA_EN
    v2_d = ld2 || (v2_q && !ld3);
`else
    v2_d = ld2 || (v2_q && !out_ready);
`endif
    s2_d = s2_q;
    if (ld2) begin
      s2_d.sum   = l5[0];
      s2_d.carry = l5[1];
    end

`ifdef BOOTH_FINAL_CPA_EN
    v3_d   = ld3 || (v3_q && !out_ready);
    s3_d   = s3_q;
    prod_d = prod_q;
    if (ld3) begin
      s3_d   = s2_q;
      prod_d = s2_q.sum + s2_q.carry;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q   <= 1'b0;
      s1_q   <= '0;
      v2_q   <= 1'b0;
      s2_q   <= '0;
`ifdef BOOTH_FINAL_CPA_EN
      v3_q   <= 1'b0;
      s3_q   <= '0;
      prod_q <= '0;
`endif
    end else begin
      v1_q   <= v1_d;
      s1_q   <= s1_d;
      v2_q   <= v2_d;
      s2_q   <= s2_d;
`ifdef BOOTH_FINAL_CPA_EN
      v3_q   <= v3_d;
      s3_q   <= s3_d;
      prod_q <= prod_d;
`endif
    end
  end

  // Outputs always come from the last stage so sum/carry stay aligned with out_prod.
  always_comb begin
`ifdef BOOTH_FINAL_CPA_EN
    out_valid = v3_q;
    out_sum   = s3_q.sum;
    out_carry = s3_q.carry;
    out_prod  = prod_q;
`else
    out_valid = v2_q;
    out_sum   = s2_q.sum;
    out_carry = s2_q.carry;
`endif
  end

endmodule
